// File: rtl/bist_fail_log.sv
// Failure logger for the SRAM BIST engine: records the first DEPTH miscompares
// (address, syndrome, popcount) and a saturating total, then freezes for readout.
module bist_fail_log #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    localparam int BITS_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] cmp_act,
    input  logic              bist_done,
    input  logic              rd_en,
    output logic              rec_valid,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_syn,
    output logic [BITS_W-1:0] rec_bits,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              log_ovf,
    output logic              log_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {
        ST_LOG     = 1'b0,
        ST_READOUT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [CNT_W-1:0]  fail_cnt_reg, fail_cnt_next;
    logic              log_ovf_reg, log_ovf_next;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_syn  [DEPTH];
    logic [BITS_W-1:0] mem_bits [DEPTH];

    logic [DATA_W-1:0] syndrome;
    logic [BITS_W-1:0] syn_pop;
    logic              miscompare;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  wr_sel;

    assign syndrome   = cmp_exp ^ cmp_act;
    assign fifo_full  = (occ_reg == OCC_W'(DEPTH));
    assign fifo_empty = (occ_reg == '0);
    // Compares are only meaningful while logging; in READOUT the inputs are ignored.
    assign miscompare = cmp_valid && (state_reg == ST_LOG) && (syndrome != '0);
    assign push       = miscompare && !fifo_full;
    assign pop        = rd_en && rec_valid;

    // Popcount is taken on the capture side so readout is a plain storage lookup.
    always_comb begin
        syn_pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            syn_pop = syn_pop + BITS_W'(syndrome[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Record storage carries no reset; contents are only observed once written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_addr[i] <= cmp_addr;
                mem_syn[i]  <= syndrome;
                mem_bits[i] <= syn_pop;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        occ_next      = occ_reg;
        fail_cnt_next = fail_cnt_reg;
        log_ovf_next  = log_ovf_reg;

        case (state_reg)
            ST_LOG: begin
                if (bist_done) begin
                    state_next = ST_READOUT;
                end
            end
            ST_READOUT: begin
                state_next = ST_READOUT;
            end
            default: begin
                state_next = ST_LOG;
            end
        endcase

        if (miscompare) begin
            if (fail_cnt_reg != '1) begin
                fail_cnt_next = fail_cnt_reg + CNT_W'(1);
            end
            // Oldest records win: a full log only flags the overflow.
            if (fifo_full) begin
                log_ovf_next = 1'b1;
            end else begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                occ_next    = occ_reg + OCC_W'(1);
            end
        end

        // Push only happens in LOG and pop only in READOUT, so they never collide.
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            occ_next    = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_LOG;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            fail_cnt_reg <= '0;
            log_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            occ_reg      <= occ_next;
            fail_cnt_reg <= fail_cnt_next;
            log_ovf_reg  <= log_ovf_next;
        end
    end

    assign rec_valid = (state_reg == ST_READOUT) && !fifo_empty;
    assign log_done  = (state_reg == ST_READOUT) && fifo_empty;
    assign rec_addr  = mem_addr[rd_ptr_reg];
    assign rec_syn   = mem_syn[rd_ptr_reg];
    assign rec_bits  = mem_bits[rd_ptr_reg];
    assign fail_cnt  = fail_cnt_reg;
    assign log_ovf   = log_ovf_reg;

endmodule

// File: tb/tb_bist_fail_log.sv
// Scoreboard bench for bist_fail_log: stimulus queues expected records, a
// negedge monitor checks every popped record; a CNT_W=4 copy checks saturation.
module tb_bist_fail_log;

    logic        clk_tb = 1'b0;
    logic        rst = 1'b1;
    logic        cmp_valid = 1'b0;
    logic [7:0]  cmp_addr = '0;
    logic [31:0] cmp_exp = '0;
    logic [31:0] cmp_act = '0;
    logic        bist_done = 1'b0;
    logic        rd_en = 1'b0;

    logic        rec_valid, log_ovf, log_done;
    logic [7:0]  rec_addr;
    logic [31:0] rec_syn;
    logic [5:0]  rec_bits;
    logic [15:0] fail_cnt;

    logic        s_rec_valid, s_log_ovf, s_log_done;
    logic [7:0]  s_rec_addr;
    logic [31:0] s_rec_syn;
    logic [5:0]  s_rec_bits;
    logic [3:0]  s_fail_cnt;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] syn;
        logic [5:0]  bits;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_rec;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk_tb = ~clk_tb;

    bist_fail_log #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk_tb), .rst(rst), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
        .cmp_exp(cmp_exp), .cmp_act(cmp_act), .bist_done(bist_done), .rd_en(rd_en),
        .rec_valid(rec_valid), .rec_addr(rec_addr), .rec_syn(rec_syn), .rec_bits(rec_bits),
        .fail_cnt(fail_cnt), .log_ovf(log_ovf), .log_done(log_done)
    );

    bist_fail_log #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk_tb), .rst(rst), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
        .cmp_exp(cmp_exp), .cmp_act(cmp_act), .bist_done(bist_done), .rd_en(rd_en),
        .rec_valid(s_rec_valid), .rec_addr(s_rec_addr), .rec_syn(s_rec_syn), .rec_bits(s_rec_bits),
        .fail_cnt(s_fail_cnt), .log_ovf(s_log_ovf), .log_done(s_log_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: each accepted pop must match the oldest queued expectation.
    always @(negedge clk_tb) begin
        if (!rst && rec_valid && rd_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got addr 0x%0h, required no record", rec_addr);
            end else begin
                mon_rec = exp_q.pop_front();
                check("pop_addr", 64'(rec_addr), 64'(mon_rec.addr));
                check("pop_syn",  64'(rec_syn),  64'(mon_rec.syn));
                check("pop_bits", 64'(rec_bits), 64'(mon_rec.bits));
                $display("pop addr=0x%02h syn=0x%08h bits=%0d", rec_addr, rec_syn, rec_bits);
            end
        end
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // One compare; when store=1 the hand-computed record is queued as expected.
    task automatic do_cmp(input logic [7:0] a, input logic [31:0] e, input logic [31:0] d,
                          input bit store, input logic [5:0] bits);
        rec_t r;
        cmp_valid = 1'b1;
        cmp_addr  = a;
        cmp_exp   = e;
        cmp_act   = d;
        if (store) begin
            r.addr = a;
            r.syn  = e ^ d;
            r.bits = bits;
            exp_q.push_back(r);
        end
        tick();
        cmp_valid = 1'b0;
    endtask

    task automatic do_done();
        bist_done = 1'b1;
        tick();
        bist_done = 1'b0;
    endtask

    task automatic do_pop(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        do_reset();
        check("rst_rec_valid", 64'(rec_valid), 64'd0);
        check("rst_log_done",  64'(log_done),  64'd0);
        check("rst_fail_cnt",  64'(fail_cnt),  64'd0);
        check("rst_log_ovf",   64'(log_ovf),   64'd0);

        // Clean run
        for (int i = 0; i < 256; i++) do_cmp(8'(i), 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 6'd0);
        do_done();
        check("clean_log_done",  64'(log_done),  64'd1);
        check("clean_fail_cnt",  64'(fail_cnt),  64'd0);
        check("clean_log_ovf",   64'(log_ovf),   64'd0);
        check("clean_rec_valid", 64'(rec_valid), 64'd0);
        $display("clean run: fail_cnt=%0d log_done=%0d", fail_cnt, log_done);

        // Single failure
        do_reset();
        do_cmp(8'h13, 32'h55555555, 32'h55555554, 1'b1, 6'd1);
        do_done();
        check("single_rec_valid", 64'(rec_valid), 64'd1);
        check("single_rec_addr",  64'(rec_addr),  64'h13);
        check("single_fail_cnt",  64'(fail_cnt),  64'd1);
        do_pop(1);
        check("single_rec_valid_after", 64'(rec_valid), 64'd0);
        check("single_log_done",        64'(log_done),  64'd1);

        // Overflow: six misses, first four kept
        do_reset();
        for (int i = 0; i < 6; i++) do_cmp(8'(i), 32'h0, 32'hFFFFFFFF, i < 4, 6'd32);
        check("ovf_fail_cnt",  64'(fail_cnt),  64'd6);
        check("ovf_log_ovf",   64'(log_ovf),   64'd1);
        check("ovf_valid_log", 64'(rec_valid), 64'd0);
        do_done();
        check("ovf_rec_bits",  64'(rec_bits),  64'd32);
        do_pop(5);
        check("ovf_log_done",  64'(log_done),  64'd1);
        check("ovf_rec_valid", 64'(rec_valid), 64'd0);
        check("ovf_fail_hold", 64'(fail_cnt),  64'd6);

        // Boundary: miscompare with bist_done, then one in READOUT
        do_reset();
        bist_done = 1'b1;
        do_cmp(8'h7F, 32'h0000F000, 32'h00000000, 1'b1, 6'd4);
        bist_done = 1'b0;
        check("bnd_fail_cnt",  64'(fail_cnt),  64'd1);
        check("bnd_rec_valid", 64'(rec_valid), 64'd1);
        do_cmp(8'h22, 32'h12345678, 32'h00000000, 1'b0, 6'd0);
        check("bnd_ro_fail_cnt", 64'(fail_cnt), 64'd1);
        check("bnd_ro_log_ovf",  64'(log_ovf),  64'd0);
        do_pop(1);
        check("bnd_log_done", 64'(log_done), 64'd1);

        // Saturation on the CNT_W=4 copy
        do_reset();
        for (int i = 0; i < 20; i++) begin
            do_cmp(8'(i), 32'h0, 32'(i + 1), i < 4,
                   (i == 0) ? 6'd1 : (i == 1) ? 6'd1 : (i == 2) ? 6'd2 : 6'd1);
            if (i == 14) check("sat_at_15", 64'(s_fail_cnt), 64'd15);
        end
        check("sat_fail_cnt",  64'(s_fail_cnt), 64'd15);
        check("sat_log_ovf",   64'(s_log_ovf),  64'd1);
        check("wide_fail_cnt", 64'(fail_cnt),   64'd20);
        do_done();
        do_pop(4);
        check("sat_drain_done", 64'(log_done), 64'd1);

        // Reset mid-READOUT
        do_reset();
        do_cmp(8'h40, 32'h0, 32'h1, 1'b1, 6'd1);
        do_cmp(8'h41, 32'h0, 32'h3, 1'b1, 6'd2);
        do_done();
        check("mid_rec_valid", 64'(rec_valid), 64'd1);
        do_reset();
        check("mid_rst_rec_valid", 64'(rec_valid), 64'd0);
        check("mid_rst_log_done",  64'(log_done),  64'd0);
        check("mid_rst_fail_cnt",  64'(fail_cnt),  64'd0);
        check("mid_rst_log_ovf",   64'(log_ovf),   64'd0);
        do_cmp(8'h50, 32'h0, 32'h80000001, 1'b1, 6'd2);
        do_pop(2);
        do_done();
        check("mid_log_rd_ignored", 64'(rec_valid), 64'd1);
        check("mid_fail_cnt",       64'(fail_cnt),  64'd1);
        do_pop(1);
        check("mid_log_done", 64'(log_done), 64'd1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_fail_log.md
# bist_fail_log

Failure logger sitting directly downstream of the `bist` SRAM self-test engine. It observes every read-compare the engine performs and records the first `DEPTH` miscompares (address, XOR syndrome, failing-bit count) in a small FIFO. It also keeps a saturating total failure count. After the engine signals completion, it freezes and lets a debug master or tester drain the records with a pop handshake.

## Interface
Parameters:
- `ADDR_W`, default 8: SRAM address width.
- `DATA_W`, default 32: SRAM word width; matches `pattern_0`/`pattern_1`.
- `DEPTH`, default 4: number of failure records stored; power of two, at least 2.
- `CNT_W`, default 16: width of the total failure counter.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmp_valid`, in, 1: a compare result is presented this cycle.
- `cmp_addr`, in, `ADDR_W`: address of the word compared.
- `cmp_exp`, in, `DATA_W`: expected pattern.
- `cmp_act`, in, `DATA_W`: data read from the SRAM (`data_output`).
- `bist_done`, in, 1: engine finished; level or pulse, sampled each cycle.
- `rd_en`, in, 1: pop the head record.
- `rec_valid`, out, 1: the head record is valid.
- `rec_addr`, out, `ADDR_W`: head record address.
- `rec_syn`, out, `DATA_W`: head record syndrome, `cmp_exp ^ cmp_act`.
- `rec_bits`, out, `$clog2(DATA_W+1)`: popcount of `rec_syn`.
- `fail_cnt`, out, `CNT_W`: total miscompares, saturating.
- `log_ovf`, out, 1: sticky; a miscompare arrived while the FIFO was full.
- `log_done`, out, 1: in READOUT and all records drained.

## Operation
- State machine has two states, LOG and READOUT. Reset enters LOG.
- LOG → READOUT at the edge where `bist_done`=1.
- READOUT exits only through `rst`.
- A miscompare is a cycle with `cmp_valid`=1 in LOG and `cmp_exp != cmp_act`. Matching compares have no effect.
- On each miscompare:
  - `fail_cnt` increments, holding at 2^`CNT_W`−1 once there.
  - If FIFO occupancy < `DEPTH`: push {`cmp_addr`, syndrome, popcount(syndrome)}; occupancy increments.
  - If FIFO occupancy = `DEPTH`: nothing is stored and `log_ovf` is set. The oldest records are kept and are never overwritten.
- Popcount is computed on the input side and stored with the record, not computed on readout.
- A miscompare in the same cycle as `bist_done` is still logged and counted.
- In READOUT, `cmp_valid` is ignored entirely, so `fail_cnt` and `log_ovf` are frozen.
- Pop rule: `rd_en`=1 while `rec_valid`=1 removes the head at the edge.
  - `rd_en` is ignored when `rec_valid`=0, including any time in LOG.
  - Pops never underflow.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is `$clog2(DEPTH)+1` bits.
- `rec_addr`, `rec_syn` and `rec_bits` are driven straight from FIFO storage at the read pointer. They are don't-care when `rec_valid`=0.
- `rec_valid` = (state==READOUT) && (occupancy≠0).
- `log_done` = (state==READOUT) && (occupancy==0).

## Timing
- Reset values:
  - state LOG; pointers and occupancy 0.
  - `fail_cnt`=0, `log_ovf`=0.
  - `rec_valid`=0, `log_done`=0.
  - Record storage is not reset; `rec_*` data outputs are undefined until written.
- Capture latency: a miscompare sampled at edge N is reflected in `fail_cnt` and occupancy after edge N.
- `bist_done` sampled at edge N: `rec_valid` can assert, and `log_done` asserts if there are zero failures, after edge N.
- Pop: with `rd_en`=1 at edge N, the next record (or `rec_valid`=0) appears after edge N. The bench can sustain one pop per cycle.
- `rst`=1 mid-LOG or mid-READOUT discards all records and counts at that edge. `rst` takes priority over every other input.
- Push and pop are never simultaneous, because the state machine separates them.

## Test plan
- Clean run:
  - Stimulus: 256 compares with `cmp_exp`=`cmp_act`=0xAAAAAAAA, then `bist_done`.
  - Response: `fail_cnt`=0, `log_ovf`=0, `rec_valid`=0, and `log_done`=1 one cycle after `bist_done`.
- Single failure:
  - Stimulus: addr 0x13, exp 0x55555555, act 0x55555554, then `bist_done`.
  - Response: `rec_valid`=1, `rec_addr`=0x13, `rec_syn`=0x00000001, `rec_bits`=1, `fail_cnt`=1. After one `rd_en`: `rec_valid`=0, `log_done`=1.
- Overflow:
  - Stimulus: 6 miscompares at addrs 0–5 with `DEPTH`=4, syndrome 0xFFFFFFFF.
  - Response: `fail_cnt`=6, `log_ovf`=1, `rec_bits`=32. Four pops return addrs 0,1,2,3 in order. A fifth `rd_en` does not change state.
- Boundary timing:
  - Stimulus: miscompare at addr 0x7F in the same cycle as `bist_done`; then `cmp_valid` with a miscompare in READOUT.
  - Response: 0x7F is logged and `fail_cnt`=1; the READOUT compare is ignored and `fail_cnt` stays 1.
- Saturation:
  - Stimulus: `CNT_W`=4, 20 consecutive miscompares.
  - Response: `fail_cnt` holds at 15 and `log_ovf`=1.
- Reset mid-operation:
  - Stimulus: 2 records in READOUT, then `rst`=1 for one cycle.
  - Response: state LOG, `rec_valid`=0, `fail_cnt`=0, `log_ovf`=0. `rd_en` in LOG has no effect.
